// File: rtl/led_matrix_pkg.sv
// Shared state encoding and parameter-derived helpers for the HUB75 BCM scan controller.
package led_matrix_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_KICK      = 3'd1,
      S_SHIFT     = 3'd2,
      S_BLANK     = 3'd3,
      S_LATCH     = 3'd4,
      S_ADV       = 3'd5,
      S_LATCH_CLR = 3'd6,
      S_UNBLANK   = 3'd7
   } state_t;

   // Width of a bit-plane index; at least one bit even for a single plane.
   function automatic int unsigned plane_bits_f(input int unsigned pwm_bits);
      return (pwm_bits > 1) ? $clog2(pwm_bits) : 1;
   endfunction

   // Width able to hold the longest on-time, BASE_ON<<(PWM_BITS-1).
   function automatic int unsigned on_w_f(input int unsigned base_on, input int unsigned pwm_bits);
      return $clog2(base_on << (pwm_bits - 1)) + 1;
   endfunction

   // On-time in clocks of bit plane b.
   function automatic int unsigned on_time(input int unsigned base_on, input int unsigned plane);
      return base_on << plane;
   endfunction

endpackage

// File: rtl/led_bcm_timer.sv
// Per-line BCM on-time counter with brightness-scaled lit window.
module led_bcm_timer
   import led_matrix_pkg::*;
#(
   parameter  int unsigned BASE_ON     = 64,
   parameter  int unsigned PWM_BITS    = 4,
   parameter  int unsigned BRIGHT_BITS = 8,
   localparam int unsigned PLANE_BITS  = plane_bits_f(PWM_BITS),
   localparam int unsigned ON_W        = on_w_f(BASE_ON, PWM_BITS)
) (
   input  logic                   clk_25MHz,
   input  logic                   rst_n,
   input  logic                   preset,
   input  logic                   load,
   input  logic                   run,
   input  logic [PLANE_BITS-1:0]  plane,
   input  logic [BRIGHT_BITS-1:0] brightness,
   output logic                   on_done,
   output logic                   blank
);

   localparam int unsigned PROD_W = ON_W + BRIGHT_BITS;

   logic [ON_W-1:0]   on_cnt;
   logic [ON_W-1:0]   duty;
   logic [ON_W-1:0]   on_lim;
   logic [ON_W-1:0]   cnt_inc;
   logic [ON_W-1:0]   duty_new;
   logic [PROD_W-1:0] product;

   // On-time limit, scaled duty and saturating count for the displayed plane.
   always_comb begin
      on_lim   = ON_W'(on_time(BASE_ON, 32'(plane)));
      product  = PROD_W'(on_lim) * PROD_W'(brightness);
      duty_new = ON_W'(product >> BRIGHT_BITS);
      cnt_inc  = on_done ? on_cnt : on_cnt + ON_W'(1);
   end

   // Counter and blank are updated one cycle ahead so blank lines up with on_cnt.
   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) begin
         on_cnt  <= '0;
         duty    <= '0;
         on_done <= 1'b0;
         blank   <= 1'b1;
      end else if (preset) begin
         on_done <= 1'b1;
         blank   <= 1'b1;
      end else if (load) begin
         on_cnt  <= '0;
         duty    <= duty_new;
         on_done <= 1'b0;
         blank   <= (duty_new == '0);
      end else if (run) begin
         on_cnt  <= cnt_inc;
         on_done <= on_done | (cnt_inc == on_lim);
         blank   <= on_done | (cnt_inc >= duty);
      end else begin
         blank   <= 1'b1;
      end
   end

endmodule

// File: rtl/led_matrix_bcm_scan.sv
// HUB75 row/bit-plane scan controller: overlaps next-line shift with display, swaps buffers at frame wrap.
module led_matrix_bcm_scan
   import led_matrix_pkg::*;
#(
   parameter  int unsigned NUM_ROWS    = 24,
   parameter  int unsigned ROW_BITS    = 5,
   parameter  int unsigned PWM_BITS    = 4,
   parameter  int unsigned BASE_ON     = 64,
   parameter  int unsigned BRIGHT_BITS = 8,
   localparam int unsigned PLANE_BITS  = plane_bits_f(PWM_BITS)
) (
   input  logic                   clk_25MHz,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [BRIGHT_BITS-1:0] brightness,
   input  logic                   swap_req,
   output logic                   swap_ack,
   output logic                   buf_sel,
   output logic                   frame_start,
   output logic [ROW_BITS-1:0]    row_addr,
   output logic                   blank,
   output logic                   latch,
   output logic                   next_line_begin,
   input  logic                   next_line_done,
   output logic [ROW_BITS-1:0]    next_line_addr,
   output logic [PLANE_BITS-1:0]  next_line_plane,
   output logic                   ram_en
);

   localparam logic [ROW_BITS-1:0]   LAST_ROW  = ROW_BITS'(NUM_ROWS - 1);
   localparam logic [PLANE_BITS-1:0] MSB_PLANE = PLANE_BITS'(PWM_BITS - 1);

   state_t                  state, state_nxt;
   logic                    latch_nxt, begin_nxt, ram_en_nxt;
   logic                    done_flag;
   logic                    on_done;
   logic [PLANE_BITS-1:0]   disp_plane;
   logic [ROW_BITS-1:0]     adv_row;
   logic [PLANE_BITS-1:0]   adv_plane;
   logic                    wrap;

   // State register.
   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and next-cycle pin values.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (enable) state_nxt = S_KICK;
         S_KICK:      state_nxt = S_SHIFT;
         S_SHIFT:     if (done_flag && on_done) state_nxt = S_BLANK;
         S_BLANK:     state_nxt = enable ? S_LATCH : S_IDLE;
         S_LATCH:     state_nxt = S_ADV;
         S_ADV:       state_nxt = S_LATCH_CLR;
         S_LATCH_CLR: state_nxt = S_UNBLANK;
         S_UNBLANK:   state_nxt = S_SHIFT;
         default:     state_nxt = S_IDLE;
      endcase
      latch_nxt  = (state_nxt == S_LATCH);
      begin_nxt  = (state_nxt == S_KICK) || (state_nxt == S_LATCH_CLR);
      ram_en_nxt = (state_nxt == S_SHIFT);
   end

   // Next-pointer advance: rows inner, planes MSB first, wrap to row 0 / MSB.
   always_comb begin
      adv_row   = next_line_addr + ROW_BITS'(1);
      adv_plane = next_line_plane;
      if (next_line_addr == LAST_ROW) begin
         adv_row   = '0;
         adv_plane = (next_line_plane == '0) ? MSB_PLANE : next_line_plane - PLANE_BITS'(1);
      end
      wrap = (adv_row == '0) && (adv_plane == MSB_PLANE);
   end

   // Registered pins, shift handshake, pointers and frame-boundary buffer swap.
   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) begin
         latch           <= 1'b0;
         next_line_begin <= 1'b0;
         ram_en          <= 1'b0;
         swap_ack        <= 1'b0;
         frame_start     <= 1'b0;
         buf_sel         <= 1'b0;
         row_addr        <= '0;
         disp_plane      <= MSB_PLANE;
         next_line_addr  <= '0;
         next_line_plane <= MSB_PLANE;
         done_flag       <= 1'b0;
      end else begin
         latch           <= latch_nxt;
         next_line_begin <= begin_nxt;
         ram_en          <= ram_en_nxt;
         swap_ack        <= 1'b0;
         frame_start     <= 1'b0;
         // A done arriving in the begin cycle itself is dropped.
         if (next_line_begin)     done_flag <= 1'b0;
         else if (next_line_done) done_flag <= 1'b1;
         if (state == S_BLANK && !enable) begin
            next_line_addr  <= '0;
            next_line_plane <= MSB_PLANE;
         end
         if (state == S_ADV) begin
            row_addr        <= next_line_addr;
            disp_plane      <= next_line_plane;
            next_line_addr  <= adv_row;
            next_line_plane <= adv_plane;
            if (wrap) begin
               frame_start <= 1'b1;
               if (swap_req) begin
                  buf_sel  <= ~buf_sel;
                  swap_ack <= 1'b1;
               end
            end
         end
      end
   end

   led_bcm_timer #(
      .BASE_ON     (BASE_ON),
      .PWM_BITS    (PWM_BITS),
      .BRIGHT_BITS (BRIGHT_BITS)
   ) u_timer (
      .clk_25MHz  (clk_25MHz),
      .rst_n      (rst_n),
      .preset     (state == S_KICK),
      .load       (state == S_UNBLANK),
      .run        (state == S_SHIFT),
      .plane      (disp_plane),
      .brightness (brightness),
      .on_done    (on_done),
      .blank      (blank)
   );

endmodule

// File: tb/tb_led_matrix_bcm_scan.sv
// Randomized bench for led_matrix_bcm_scan with a line-level reference model and shifter model.
module tb_led_matrix_bcm_scan;

   localparam int NR    = 4;
   localparam int RB    = 2;
   localparam int PB    = 2;
   localparam int BO    = 8;
   localparam int BB    = 8;
   localparam int FRAME = NR * PB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [BB-1:0] brightness;
   logic          swap_req;
   logic          swap_ack, buf_sel, frame_start, blank, latch, next_line_begin, ram_en;
   logic          next_line_done;
   logic [RB-1:0] row_addr, next_line_addr;
   logic [0:0]    next_line_plane;

   led_matrix_bcm_scan #(
      .NUM_ROWS(NR), .ROW_BITS(RB), .PWM_BITS(PB), .BASE_ON(BO), .BRIGHT_BITS(BB)
   ) dut (
      .clk_25MHz(clk), .rst_n(rst_n), .enable(enable), .brightness(brightness),
      .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel), .frame_start(frame_start),
      .row_addr(row_addr), .blank(blank), .latch(latch), .next_line_begin(next_line_begin),
      .next_line_done(next_line_done), .next_line_addr(next_line_addr),
      .next_line_plane(next_line_plane), .ram_en(ram_en)
   );

   always #20 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   int shift_delay = 3;
   int pend        = 0;
   bit done_given  = 0;
   int line_idx    = 0;
   int lat_idx     = 0;
   int lit_cnt     = 0;
   int seg_len     = 0;
   int seg_bright  = 0;
   bit prev_latch  = 0;
   bit exp_buf     = 0;
   bit pending     = 0;
   int begins_seen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int duty_of(input int plane, input int b);
      return ((BO << plane) * b) >> BB;
   endfunction

   function automatic int plane_of(input int idx);
      return PB - 1 - ((idx / NR) % PB);
   endfunction

   task automatic reset_lines();
      line_idx   = 0;
      lat_idx    = 0;
      lit_cnt    = 0;
      seg_len    = 0;
      prev_latch = 0;
   endtask

   // One clock: sample outputs after the edge, run shifter model and line checks.
   task automatic tick();
      bit boundary, ack_exp;
      int lj;
      @(posedge clk);
      #1;
      next_line_done = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            next_line_done = 1'b1;
            done_given     = 1;
         end
      end
      check("fs_stray", 32'(frame_start & ~next_line_begin), 0);
      check("ack_stray", 32'(swap_ack & ~frame_start), 0);
      if (next_line_begin === 1'b1) begin
         begins_seen++;
         boundary = (line_idx > 0) && (line_idx % FRAME == 0);
         ack_exp  = 0;
         if (boundary && pending) begin
            exp_buf  = !exp_buf;
            pending  = 0;
            swap_req = 1'b0;
            ack_exp  = 1;
         end
         check("begin_row", 32'(next_line_addr), line_idx % NR);
         check("begin_plane", 32'(next_line_plane), plane_of(line_idx));
         check("frame_start", 32'(frame_start), 32'(boundary));
         check("swap_ack", 32'(swap_ack), 32'(ack_exp));
         check("buf_sel", 32'(buf_sel), 32'(exp_buf));
         if (line_idx % FRAME == 2 && !pending) begin
            swap_req = 1'b1;
            pending  = 1;
         end
         done_given = 0;
         pend       = shift_delay;
         line_idx++;
      end
      if (blank === 1'b0) lit_cnt++;
      seg_len++;
      if (latch === 1'b1) begin
         check("latch_width", 32'(prev_latch), 0);
         check("latch_after_done", 32'(done_given), 1);
         if (lat_idx == 0) begin
            check("lit_before_first", lit_cnt, 0);
         end else begin
            lj = lat_idx - 1;
            check("lit_cycles", lit_cnt, duty_of(plane_of(lj), seg_bright));
            check("row_addr", 32'(row_addr), lj % NR);
            check("period_ge_on", 32'(seg_len >= (BO << plane_of(lj)) + 5), 1);
         end
         case ($urandom_range(0, 3))
            0:       brightness = 8'd0;
            1:       brightness = 8'd128;
            2:       brightness = 8'd255;
            default: brightness = 8'($urandom_range(0, 255));
         endcase
         seg_bright = int'(brightness);
         lit_cnt    = 0;
         seg_len    = 0;
         lat_idx++;
      end
      prev_latch = (latch === 1'b1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_ram_en(input string tag);
      int k;
      k = 0;
      while (ram_en !== 1'b1 && k < 400) begin
         tick();
         k++;
      end
      check(tag, 32'(ram_en), 1);
   endtask

   initial begin
      int b0;
      rst_n          = 1'b0;
      enable         = 1'b0;
      brightness     = 8'd128;
      swap_req       = 1'b0;
      next_line_done = 1'b0;
      run(2);
      rst_n = 1'b1;
      run(5);
      check("rst_blank", 32'(blank), 1);
      check("rst_latch", 32'(latch), 0);
      check("rst_row", 32'(row_addr), 0);
      check("rst_buf", 32'(buf_sel), 0);
      check("rst_ram_en", 32'(ram_en), 0);
      check("rst_begins", begins_seen, 0);

      // Normal scan, fast shifter, random brightness, swaps each frame.
      reset_lines();
      enable = 1'b1;
      run(700);

      // Slow shifter: blanking stretches, latch waits for done.
      shift_delay = 100;
      run(900);

      // Disable mid-shift, then restart from row 0 / MSB with buffer kept.
      shift_delay = 3;
      wait_ram_en("wait_shift_dis");
      enable = 1'b0;
      b0 = begins_seen;
      run(200);
      check("dis_no_begin", begins_seen - b0, 0);
      check("dis_blank", 32'(blank), 1);
      check("dis_ram_en", 32'(ram_en), 0);
      check("dis_latch", 32'(latch), 0);
      check("dis_buf_kept", 32'(buf_sel), 32'(exp_buf));
      reset_lines();
      enable = 1'b1;
      run(300);

      // Reset in the middle of a line.
      wait_ram_en("wait_shift_rst");
      rst_n = 1'b0;
      tick();
      check("mid_rst_blank", 32'(blank), 1);
      check("mid_rst_latch", 32'(latch), 0);
      check("mid_rst_begin", 32'(next_line_begin), 0);
      check("mid_rst_ram_en", 32'(ram_en), 0);
      check("mid_rst_ack", 32'(swap_ack), 0);
      check("mid_rst_fs", 32'(frame_start), 0);
      check("mid_rst_buf", 32'(buf_sel), 0);
      check("mid_rst_row", 32'(row_addr), 0);
      check("mid_rst_naddr", 32'(next_line_addr), 0);
      check("mid_rst_nplane", 32'(next_line_plane), PB - 1);
      exp_buf        = 0;
      pending        = 0;
      swap_req       = 1'b0;
      pend           = 0;
      done_given     = 0;
      next_line_done = 1'b0;
      reset_lines();
      rst_n = 1'b1;
      run(400);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
